// File: rtl/md_pkg.sv
// Shared definitions for the mult/div source stage.
// The hazard unit uses the same state encoding and default latencies.
// Contents:
//   md_state_t     sequencing states (IDLE / BUSY / DONE)
//   MD_MUL_CYCLES  default multiply latency in busy cycles
//   MD_DIV_CYCLES  default divide latency in busy cycles
package md_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam int MD_MUL_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter that tracks the busy cycles left in a mult/div operation.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-low (0 = reset)
//   clear     force the count to zero (flush)
//   load      load load_val (operation accepted)
//   load_val  latency to load
//   dec       decrement by one (one busy cycle consumed)
//   count     current count
//   last      count == 1, so this is the final busy cycle
// Priority, highest first: reset, clear, load, dec.
module md_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == CNT_W'(1));

endmodule

// File: rtl/md_source_stage.sv
// Operand-capture and latency-sequencing stage for the mult/div unit.
// Captures operands and control on an accepted start. Holds them steady while the
// datapath works for the multiply or divide latency. Reports busy/done to the stall
// logic.
// Ports:
//   clk, reset                  clock; synchronous active-low reset
//   src_A, src_B, src_ctrl      operands and control word from EX
//   src_is_div                  selects DIV_CYCLES (1) or MUL_CYCLES (0)
//   start, flush                begin an operation / abandon the current one
//   A, B, real_ctrl             captured operands and control
//   busy, done, remaining       registered status (remaining counts the current cycle)
module md_source_stage
  import md_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] src_A,
  input  logic [DATA_W-1:0] src_B,
  input  logic [CTRL_W-1:0] src_ctrl,
  input  logic              src_is_div,
  input  logic              start,
  input  logic              flush,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [CTRL_W-1:0] real_ctrl,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  remaining
);

  localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);

  md_state_t         state_reg, state_next;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic              accept;
  logic              cnt_last;
  logic [CNT_W-1:0]  cnt_value;

  // A start while the datapath is busy is dropped. Flush overrides start.
  assign accept = start && !flush && (state_reg != MD_BUSY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= MD_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = MD_IDLE;
    end else begin
      case (state_reg)
        MD_IDLE: if (accept)   state_next = MD_BUSY;
        MD_BUSY: if (cnt_last) state_next = MD_DONE;
        MD_DONE: state_next = accept ? MD_BUSY : MD_IDLE;
        default: state_next = MD_IDLE;
      endcase
    end
  end

  // Capture registers change only on an accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      ctrl_reg <= '0;
    end else if (accept) begin
      a_reg    <= src_A;
      b_reg    <= src_B;
      ctrl_reg <= src_ctrl;
    end
  end

  md_latency_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .load     (accept),
    .load_val (src_is_div ? DIV_N : MUL_N),
    .dec      (state_reg == MD_BUSY),
    .count    (cnt_value),
    .last     (cnt_last)
  );

  assign A         = a_reg;
  assign B         = b_reg;
  assign real_ctrl = ctrl_reg;
  assign busy      = (state_reg == MD_BUSY);
  assign done      = (state_reg == MD_DONE);
  assign remaining = cnt_value;

endmodule

// File: tb/tb_md_source_stage.sv
module tb_md_source_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src_A, src_B;
  logic [3:0]  src_ctrl;
  logic        src_is_div, start, flush;
  logic [31:0] A, B;
  logic [3:0]  real_ctrl;
  logic        busy, done;
  logic [3:0]  remaining;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    int          n;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  md_source_stage dut (
    .clk        (clk),
    .reset      (reset),
    .src_A      (src_A),
    .src_B      (src_B),
    .src_ctrl   (src_ctrl),
    .src_is_div (src_is_div),
    .start      (start),
    .flush      (flush),
    .A          (A),
    .B          (B),
    .real_ctrl  (real_ctrl),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive an accepted start for one edge and record the expected outcome.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic div);
    exp_t e;
    src_A = a; src_B = b; src_ctrl = c; src_is_div = div; start = 1'b1;
    e.a = a; e.b = b; e.c = c; e.n = div ? 10 : 5;
    exp_q.push_back(e);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  // Monitor: measures each busy run and checks it against the scoreboard when done pulses.
  int run_len = 0;
  always @(negedge clk) begin
    if (!reset) begin
      run_len = 0;
    end else begin
      if (busy) begin
        run_len++;
        if (exp_q.size() == 0) begin
          chk("busy_without_op", 64'd1, 64'd0);
        end else begin
          chk("remaining", 64'(remaining), 64'(exp_q[0].n - run_len + 1));
        end
      end else begin
        chk("remaining_idle", 64'(remaining), 64'd0);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("busy_len", 64'(run_len), 64'(e.n));
          chk("done_A", 64'(A), 64'(e.a));
          chk("done_B", 64'(B), 64'(e.b));
          chk("done_ctrl", 64'(real_ctrl), 64'(e.c));
          $display("txn: A=%08h B=%08h ctrl=%0h busy_cycles=%0d", A, B, real_ctrl, run_len);
        end
        run_len = 0;
      end else if (!busy) begin
        run_len = 0;
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b1; flush = 1'b0; src_is_div = 1'b0;
    src_A = 32'hDEAD_BEEF; src_B = 32'h1234_5678; src_ctrl = 4'hF;

    // Reset held with start asserted.
    step(); step();
    chk("rst_A", 64'(A), 64'd0);
    chk("rst_B", 64'(B), 64'd0);
    chk("rst_ctrl", 64'(real_ctrl), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_remaining", 64'(remaining), 64'd0);
    start = 1'b0;
    reset = 1'b1;
    step();

    // Multiply, 5 busy cycles.
    issue(32'h0000_0007, 32'hFFFF_FFFE, 4'h1, 1'b0);
    chk("mul_busy", 64'(busy), 64'd1);
    wait_done("mul_done_timeout");
    step();
    chk("mul_idle_busy", 64'(busy), 64'd0);
    chk("mul_idle_done", 64'(done), 64'd0);
    chk("mul_hold_A", 64'(A), 64'h7);

    // Divide with a start re-driven in busy cycle 3: ignored.
    issue(32'h0000_0064, 32'h0000_0003, 4'h5, 1'b1);
    step(); step();
    src_A = 32'hAAAA_AAAA; src_B = 32'h5555_5555; src_ctrl = 4'h9; src_is_div = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("div_ignore_A", 64'(A), 64'h64);
    wait_done("div_done_timeout");

    // Back-to-back: start in the DONE cycle.
    issue(32'h1234_0000, 32'h0000_4321, 4'h2, 1'b0);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_A", 64'(A), 64'h1234_0000);
    wait_done("b2b_done_timeout");
    step();

    // Flush at busy cycle 2 of a multiply.
    issue(32'h0000_00AB, 32'h0000_00CD, 4'h3, 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    void'(exp_q.pop_back());
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_remaining", 64'(remaining), 64'd0);
    chk("flush_hold_A", 64'(A), 64'hAB);
    for (int i = 0; i < 8; i++) step();
    chk("flush_no_done", 64'(done), 64'd0);

    // start and flush together in IDLE: nothing captured.
    src_A = 32'hFEED_FACE; src_B = 32'hCAFE_0001; src_ctrl = 4'hE; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    chk("sf_busy", 64'(busy), 64'd0);
    chk("sf_A", 64'(A), 64'hAB);
    chk("sf_ctrl", 64'(real_ctrl), 64'h3);
    step();

    // Reset at busy cycle 4 of a divide.
    issue(32'h0000_0F00, 32'h0000_0010, 4'h6, 1'b1);
    step(); step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    void'(exp_q.pop_back());
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_remaining", 64'(remaining), 64'd0);
    chk("mrst_A", 64'(A), 64'd0);
    chk("mrst_ctrl", 64'(real_ctrl), 64'd0);
    for (int i = 0; i < 12; i++) step();
    chk("mrst_no_done", 64'(done), 64'd0);

    // Recovery after reset.
    issue(32'h0000_0002, 32'h0000_0003, 4'h4, 1'b0);
    wait_done("rec_done_timeout");
    step(); step();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
